// File: rtl/gauss_row_feeder_pkg.sv
// -----------------------------------------------------------------------------
// gauss_row_feeder_pkg
//
// Shared encodings for the Gaussian-elimination row feeder and the processor
// array it drives: processor op codes, gauss_op sub-codes and the feeder FSM
// state encoding. Every file of the feeder imports this package so the
// encodings have a single source.
// -----------------------------------------------------------------------------
package gauss_row_feeder_pkg;

    // Processor op codes (4-bit canonical form; the feeder extends them to
    // OP_CODE_LEN bits).
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_GAUSS = 4'b0001;

    // gauss_op sub-codes carried alongside OP_GAUSS.
    localparam logic [1:0] GAUSS_PASS = 2'b00;
    localparam logic [1:0] GAUSS_ADD  = 2'b10;
    localparam logic [1:0] GAUSS_PIV  = 2'b11;

    // Feeder job sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // The first row of a job is the pivot row; every later row is added
    // (eliminated) against it.
    function automatic logic [1:0] row_gauss_op(input logic first_row);
        return first_row ? GAUSS_PIV : GAUSS_ADD;
    endfunction

endpackage

// File: rtl/gauss_row_feeder_if.sv
// -----------------------------------------------------------------------------
// gauss_row_feeder_if
//
// Bundles the feeder's job command handshake, row handshake, per-column
// processor drive and status signals.
//
//   cmd_valid / cmd_ready  job-start handshake, cmd_rows = rows in the job
//   in_valid  / in_ready   row handshake, in_data = one matrix row
//                          (column c at [c*GF_BIT +: GF_BIT])
//   out_start, out_op,     per-column start_in / op_in / gauss_op_in /
//   out_gauss_op, out_data data_in drive towards the processor columns
//   busy, done             status: busy outside IDLE, done pulses at job end
//
// Modports: master = job/row source (and status observer), slave = feeder.
// -----------------------------------------------------------------------------
interface gauss_row_feeder_if
    import gauss_row_feeder_pkg::*;
#(
    parameter int GF_BIT       = 4,
    parameter int OP_CODE_LEN  = 4,
    parameter int NUM_PROC_COL = 3,
    parameter int ROW_W        = 8
);

    logic                                 cmd_valid;
    logic                                 cmd_ready;
    logic [ROW_W-1:0]                     cmd_rows;

    logic                                 in_valid;
    logic                                 in_ready;
    logic [NUM_PROC_COL*GF_BIT-1:0]       in_data;

    logic [NUM_PROC_COL-1:0]              out_start;
    logic [NUM_PROC_COL*OP_CODE_LEN-1:0]  out_op;
    logic [2*NUM_PROC_COL-1:0]            out_gauss_op;
    logic [NUM_PROC_COL*GF_BIT-1:0]       out_data;

    logic                                 busy;
    logic                                 done;

    modport master (
        output cmd_valid, cmd_rows, in_valid, in_data,
        input  cmd_ready, in_ready,
        input  out_start, out_op, out_gauss_op, out_data,
        input  busy, done
    );

    modport slave (
        input  cmd_valid, cmd_rows, in_valid, in_data,
        output cmd_ready, in_ready,
        output out_start, out_op, out_gauss_op, out_data,
        output busy, done
    );

endinterface

// File: rtl/gauss_row_feeder_skew_lane.sv
// -----------------------------------------------------------------------------
// skew_lane
//
// Fixed-depth registered delay line for one processor column. A token
// presented on tok_in appears on tok_out exactly DEPTH cycles later. Reset
// (asynchronous, active-high) fills every tap with RST_TOK so the column sees
// idle tokens immediately.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   tok_in   token entering the lane this cycle
//   tok_out  token leaving the lane (registered, DEPTH cycles old)
// -----------------------------------------------------------------------------
module skew_lane
    import gauss_row_feeder_pkg::*;
#(
    parameter int               DEPTH   = 1,
    parameter int               TOK_W   = 8,
    parameter logic [TOK_W-1:0] RST_TOK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TOK_W-1:0] tok_in,
    output logic [TOK_W-1:0] tok_out
);

    logic [TOK_W-1:0] tap_p [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tap_p[i] <= RST_TOK;
            end
        end else begin
            tap_p[0] <= tok_in;
            for (int i = 1; i < DEPTH; i++) begin
                tap_p[i] <= tap_p[i-1];
            end
        end
    end

    assign tok_out = tap_p[DEPTH-1];

endmodule

// File: rtl/gauss_row_feeder.sv
// -----------------------------------------------------------------------------
// gauss_row_feeder
//
// Feeds matrix rows into a systolic Gaussian-elimination processor array.
// A job is started with a command giving its row count; rows are then
// accepted one per handshake and broken into per-column tokens
// {start, op, gauss_op, data}. Column c receives its token c+1 cycles after
// the row handshake so the array sees the classic diagonal skew. After the
// last row the feeder keeps injecting bubbles until the last column has
// received its final element, then pulses done for one cycle.
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-high reset; discards any job in flight
//   bus  gauss_row_feeder_if.slave
//        cmd_valid/cmd_ready/cmd_rows   job start
//        in_valid/in_ready/in_data      rows
//        out_start/out_op/out_gauss_op/out_data  per-column processor drive
//        busy (not IDLE), done (one-cycle pulse at job end)
// -----------------------------------------------------------------------------
module gauss_row_feeder
    import gauss_row_feeder_pkg::*;
#(
    parameter int GF_BIT       = 4,
    parameter int OP_CODE_LEN  = 4,
    parameter int NUM_PROC_COL = 3,
    parameter int ROW_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    gauss_row_feeder_if.slave  bus
);

    localparam int TOK_W   = 1 + OP_CODE_LEN + 2 + GF_BIT;
    localparam int DRAIN_W = $clog2(NUM_PROC_COL + 1);

    localparam logic [OP_CODE_LEN-1:0] OP_NOP_W   = OP_CODE_LEN'(OP_NOP);
    localparam logic [OP_CODE_LEN-1:0] OP_GAUSS_W = OP_CODE_LEN'(OP_GAUSS);

    // Idle token: no start, NOP, pass-through, zero data.
    localparam logic [TOK_W-1:0] BUBBLE_TOK =
        {1'b0, OP_NOP_W, GAUSS_PASS, {GF_BIT{1'b0}}};

    feeder_state_e        state, state_nxt;
    logic [ROW_W-1:0]     row_cnt, row_cnt_nxt;
    logic                 first_row, first_row_nxt;
    logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_nxt;
    logic                 accept;

    logic [TOK_W-1:0]     lane_in  [NUM_PROC_COL];
    logic [TOK_W-1:0]     lane_out [NUM_PROC_COL];

    logic [NUM_PROC_COL-1:0]             out_start_w;
    logic [NUM_PROC_COL*OP_CODE_LEN-1:0] out_op_w;
    logic [2*NUM_PROC_COL-1:0]           out_gauss_op_w;
    logic [NUM_PROC_COL*GF_BIT-1:0]      out_data_w;

    // -------------------------------------------------------------------------
    // Handshakes and status
    // -------------------------------------------------------------------------
    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.in_ready  = (state == ST_STREAM);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);

    assign accept = (state == ST_STREAM) && bus.in_valid;

    // -------------------------------------------------------------------------
    // Job sequencing: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            row_cnt   <= '0;
            first_row <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            row_cnt   <= row_cnt_nxt;
            first_row <= first_row_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Job sequencing: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        row_cnt_nxt   = row_cnt;
        first_row_nxt = first_row;
        drain_cnt_nxt = drain_cnt;

        unique case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    row_cnt_nxt   = bus.cmd_rows;
                    first_row_nxt = 1'b1;
                    // An empty job has nothing to stream or drain.
                    state_nxt     = (bus.cmd_rows == '0) ? ST_DONE : ST_STREAM;
                end
            end

            ST_STREAM: begin
                if (bus.in_valid) begin
                    // row_cnt is at least 1 here, so the decrement never wraps.
                    row_cnt_nxt   = row_cnt - ROW_W'(1);
                    first_row_nxt = 1'b0;
                    if (row_cnt == ROW_W'(1)) begin
                        // The drain covers the extra skew of columns 1..N-1;
                        // a single column has no extra skew to wait out.
                        if (NUM_PROC_COL == 1) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt     = ST_DRAIN;
                            drain_cnt_nxt = DRAIN_W'(NUM_PROC_COL - 1);
                        end
                    end
                end
            end

            ST_DRAIN: begin
                if (drain_cnt == DRAIN_W'(1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Token build: every lane gets either this row's element or a bubble
    // -------------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < NUM_PROC_COL; c++) begin
            lane_in[c] = BUBBLE_TOK;
            if (accept) begin
                lane_in[c] = {first_row, OP_GAUSS_W, row_gauss_op(first_row),
                              bus.in_data[c*GF_BIT +: GF_BIT]};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Column skew: column c delays its token by c+1 registers
    // -------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_PROC_COL; c++) begin : g_lane
        skew_lane #(
            .DEPTH   (c + 1),
            .TOK_W   (TOK_W),
            .RST_TOK (BUBBLE_TOK)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .tok_in  (lane_in[c]),
            .tok_out (lane_out[c])
        );
    end

    // -------------------------------------------------------------------------
    // Unpack lane tokens onto the per-column processor drive buses
    // -------------------------------------------------------------------------
    always_comb begin
        out_start_w    = '0;
        out_op_w       = '0;
        out_gauss_op_w = '0;
        out_data_w     = '0;
        for (int c = 0; c < NUM_PROC_COL; c++) begin
            out_start_w[c]                          = lane_out[c][TOK_W-1];
            out_op_w[c*OP_CODE_LEN +: OP_CODE_LEN]  = lane_out[c][TOK_W-2 -: OP_CODE_LEN];
            out_gauss_op_w[2*c +: 2]                = lane_out[c][GF_BIT+1 -: 2];
            out_data_w[c*GF_BIT +: GF_BIT]          = lane_out[c][GF_BIT-1:0];
        end
    end

    assign bus.out_start    = out_start_w;
    assign bus.out_op       = out_op_w;
    assign bus.out_gauss_op = out_gauss_op_w;
    assign bus.out_data     = out_data_w;

endmodule

// File: tb/tb_gauss_row_feeder.sv
// -----------------------------------------------------------------------------
// tb_gauss_row_feeder
//
// Self-checking bench for gauss_row_feeder. A 3-column instance carries most
// scenarios; a 1-column instance covers the no-drain case. Expected outputs
// come from a job timeline: each job's accepted-row cycles, busy span and
// done cycle are worked out arithmetically while stimulus is driven, and the
// expected token of column c at cycle n is the row accepted at cycle n-c-1.
// -----------------------------------------------------------------------------
module tb_gauss_row_feeder;
    import gauss_row_feeder_pkg::*;

    localparam int NC   = 3;
    localparam int GF   = 4;
    localparam int OPL  = 4;
    localparam int RW   = 8;
    localparam int DW   = NC * GF;
    localparam int OW   = NC + NC*OPL + 2*NC + NC*GF;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gauss_row_feeder_if #(.GF_BIT(GF), .OP_CODE_LEN(OPL), .NUM_PROC_COL(NC), .ROW_W(RW)) if3();
    gauss_row_feeder_if #(.GF_BIT(GF), .OP_CODE_LEN(OPL), .NUM_PROC_COL(1),  .ROW_W(RW)) if1();

    gauss_row_feeder #(.GF_BIT(GF), .OP_CODE_LEN(OPL), .NUM_PROC_COL(NC), .ROW_W(RW)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    gauss_row_feeder #(.GF_BIT(GF), .OP_CODE_LEN(OPL), .NUM_PROC_COL(1), .ROW_W(RW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // Cycle index: cycle n is the clock period following the n-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle samples of the 3-column DUT, taken mid-period.
    logic [OW-1:0] s_out [MAXC];
    logic [3:0]    s_ctl [MAXC];   // {done, busy, in_ready, cmd_ready}
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            s_out[cyc] <= {if3.out_start, if3.out_op, if3.out_gauss_op, if3.out_data};
            s_ctl[cyc] <= {if3.done, if3.busy, if3.in_ready, if3.cmd_ready};
        end
    end

    // Job timeline model.
    bit            m_acc    [MAXC];
    bit            m_first  [MAXC];
    bit            m_done   [MAXC];
    bit            m_busy   [MAXC];
    bit            m_stream [MAXC];
    logic [DW-1:0] m_row    [MAXC];

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] job_data [$];
    int            job_gap  [$];

    function automatic logic [OW-1:0] exp_out(input int n);
        logic [NC-1:0]     st;
        logic [NC*OPL-1:0] op;
        logic [2*NC-1:0]   g;
        logic [NC*GF-1:0]  d;
        st = '0; op = '0; g = '0; d = '0;
        for (int c = 0; c < NC; c++) begin
            int k;
            k = n - c - 1;
            if (k >= 0 && m_acc[k]) begin
                st[c]            = m_first[k];
                op[c*OPL +: OPL] = 4'b0001;
                g[2*c +: 2]      = m_first[k] ? 2'b11 : 2'b10;
                d[c*GF +: GF]    = m_row[k][c*GF +: GF];
            end
        end
        return {st, op, g, d};
    endfunction

    function automatic logic [3:0] exp_ctl(input int n);
        return {m_done[n], m_busy[n], m_stream[n], ~m_busy[n]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one job on the 3-column DUT starting in the current (IDLE) cycle
    // and records its timeline. Returns with the bench in the cycle after done.
    task automatic drive_job(input bit hold, output int h, output int d);
        int nrows;
        int last;
        nrows = job_data.size();
        h = cyc;
        if3.cmd_valid = 1'b1;
        if3.cmd_rows  = RW'(nrows);
        if3.in_valid  = 1'($urandom);
        if3.in_data   = DW'($urandom);
        step();
        if (!hold) begin
            if3.cmd_valid = 1'b0;
            if3.cmd_rows  = RW'($urandom);
        end
        if (nrows == 0) begin
            m_busy[cyc] = 1'b1;
            m_done[cyc] = 1'b1;
            d = cyc;
            if3.in_valid = 1'($urandom);
            step();
        end else begin
            for (int k = 0; k < nrows; k++) begin
                int g;
                g = (k < job_gap.size()) ? job_gap[k] : 0;
                for (int i = 0; i < g; i++) begin
                    m_busy[cyc]   = 1'b1;
                    m_stream[cyc] = 1'b1;
                    if3.in_valid  = 1'b0;
                    if3.in_data   = DW'($urandom);
                    step();
                end
                m_busy[cyc]   = 1'b1;
                m_stream[cyc] = 1'b1;
                m_acc[cyc]    = 1'b1;
                m_first[cyc]  = (k == 0);
                m_row[cyc]    = job_data[k];
                if3.in_valid  = 1'b1;
                if3.in_data   = job_data[k];
                step();
            end
            last = cyc - 1;
            d = last + NC;
            while (cyc <= d) begin
                m_busy[cyc]  = 1'b1;
                m_done[cyc]  = (cyc == d);
                if3.in_valid = 1'($urandom);
                if3.in_data  = DW'($urandom);
                step();
            end
        end
    endtask

    task automatic test_reset();
        if3.cmd_valid = 1'b1; if3.cmd_rows = 8'd2; if3.in_valid = 1'b1;
        if1.cmd_valid = 1'b1; if1.cmd_rows = 8'd2; if1.in_valid = 1'b1;
        step(); step();
        n_total++;
        if ({if3.cmd_ready, if3.in_ready, if3.busy, if3.done} !== 4'b1000)
            $display("FAIL reset_ctl3 got=%b exp=1000", {if3.cmd_ready, if3.in_ready, if3.busy, if3.done});
        else n_pass++;
        n_total++;
        if ({if3.out_start, if3.out_op, if3.out_gauss_op, if3.out_data} !== '0)
            $display("FAIL reset_out3 got=%h exp=0", {if3.out_start, if3.out_op, if3.out_gauss_op, if3.out_data});
        else n_pass++;
        n_total++;
        if ({if1.cmd_ready, if1.in_ready, if1.busy, if1.done, if1.out_start, if1.out_op, if1.out_gauss_op, if1.out_data} !== 15'b100_0000_0000_0000)
            $display("FAIL reset_dut1 got=%b exp=%b", {if1.cmd_ready, if1.in_ready, if1.busy, if1.done, if1.out_start, if1.out_op, if1.out_gauss_op, if1.out_data}, 15'b100_0000_0000_0000);
        else n_pass++;
        if3.cmd_valid = 1'b0; if3.in_valid = 1'b0;
        if1.cmd_valid = 1'b0; if1.in_valid = 1'b0;
        rst = 1'b0;
        step();
        n_total++;
        if ({if3.busy, if3.cmd_ready} !== 2'b01)
            $display("FAIL reset_release got=%b exp=01", {if3.busy, if3.cmd_ready});
        else n_pass++;
    endtask

    task automatic test_basic();
        int h, d;
        job_data = '{12'h321, 12'h654};
        job_gap.delete();
        drive_job(1'b0, h, d);
        step();
        for (int n = h; n <= d + 1; n++) begin
            n_total++;
            if (s_out[n] !== exp_out(n)) $display("FAIL basic_tok cyc=%0d got=%h exp=%h", n, s_out[n], exp_out(n));
            else n_pass++;
            n_total++;
            if (s_ctl[n] !== exp_ctl(n)) $display("FAIL basic_ctl cyc=%0d got=%b exp=%b", n, s_ctl[n], exp_ctl(n));
            else n_pass++;
        end
        n_total++;
        if ({s_out[h+2][3:0], s_out[h+3][3:0]} !== 8'h14)
            $display("FAIL basic_col0 got=%h exp=14", {s_out[h+2][3:0], s_out[h+3][3:0]});
        else n_pass++;
        n_total++;
        if ({s_out[h+4][11:8], s_out[h+5][11:8]} !== 8'h36)
            $display("FAIL basic_col2 got=%h exp=36", {s_out[h+4][11:8], s_out[h+5][11:8]});
        else n_pass++;
        n_total++;
        if ({s_out[h+4][OW-1], s_out[h+5][OW-1], s_out[h+2][OW-3], s_out[h+3][OW-3]} !== 4'b1010)
            $display("FAIL basic_start got=%b exp=1010", {s_out[h+4][OW-1], s_out[h+5][OW-1], s_out[h+2][OW-3], s_out[h+3][OW-3]});
        else n_pass++;
        n_total++;
        if ({s_ctl[h+4][3], s_ctl[h+5][3], s_ctl[h+6][3]} !== 3'b010)
            $display("FAIL basic_done got=%b exp=010", {s_ctl[h+4][3], s_ctl[h+5][3], s_ctl[h+6][3]});
        else n_pass++;
    endtask

    task automatic test_zero_rows();
        int h, d;
        job_data.delete();
        job_gap.delete();
        drive_job(1'b0, h, d);
        step(); step(); step();
        for (int n = h; n <= d + 3; n++) begin
            n_total++;
            if (s_out[n] !== exp_out(n)) $display("FAIL zero_tok cyc=%0d got=%h exp=%h", n, s_out[n], exp_out(n));
            else n_pass++;
            n_total++;
            if (s_ctl[n] !== exp_ctl(n)) $display("FAIL zero_ctl cyc=%0d got=%b exp=%b", n, s_ctl[n], exp_ctl(n));
            else n_pass++;
        end
        n_total++;
        if (s_ctl[h+1][3] !== 1'b1) $display("FAIL zero_done got=%b exp=1", s_ctl[h+1][3]);
        else n_pass++;
    endtask

    task automatic test_bubbles();
        int h, d;
        job_data = '{DW'($urandom), DW'($urandom), DW'($urandom)};
        job_gap  = '{0, 0, 2};
        drive_job(1'b0, h, d);
        step();
        for (int n = h; n <= d + 1; n++) begin
            n_total++;
            if (s_out[n] !== exp_out(n)) $display("FAIL bubble_tok cyc=%0d got=%h exp=%h", n, s_out[n], exp_out(n));
            else n_pass++;
            n_total++;
            if (s_ctl[n] !== exp_ctl(n)) $display("FAIL bubble_ctl cyc=%0d got=%b exp=%b", n, s_ctl[n], exp_ctl(n));
            else n_pass++;
        end
        // Rows at h+1, h+2, h+5: col0 sees row1 at h+3, bubbles h+4/h+5, row2 h+6.
        n_total++;
        if ({s_out[h+3][13:12], s_out[h+4][13:12], s_out[h+5][13:12], s_out[h+6][13:12]} !== 8'b10_00_00_10)
            $display("FAIL bubble_gop0 got=%b exp=10000010", {s_out[h+3][13:12], s_out[h+4][13:12], s_out[h+5][13:12], s_out[h+6][13:12]});
        else n_pass++;
        n_total++;
        if ({s_out[h+5][17:16], s_out[h+6][17:16], s_out[h+7][17:16], s_out[h+8][17:16]} !== 8'b10_00_00_10)
            $display("FAIL bubble_gop2 got=%b exp=10000010", {s_out[h+5][17:16], s_out[h+6][17:16], s_out[h+7][17:16], s_out[h+8][17:16]});
        else n_pass++;
    endtask

    task automatic test_reset_mid_job();
        int rel;
        if3.cmd_valid = 1'b1; if3.cmd_rows = 8'd3;
        step();
        if3.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if3.in_valid = 1'b1;
            if3.in_data  = DW'($urandom);
            step();
        end
        if3.in_valid = 1'b0;
        // Column 2 still holds rows 1 and 2 at this point.
        rst = 1'b1;
        #1;
        n_total++;
        if ({if3.out_start, if3.out_op, if3.out_gauss_op, if3.out_data} !== '0)
            $display("FAIL rstmid_out got=%h exp=0", {if3.out_start, if3.out_op, if3.out_gauss_op, if3.out_data});
        else n_pass++;
        n_total++;
        if ({if3.cmd_ready, if3.in_ready, if3.busy, if3.done} !== 4'b1000)
            $display("FAIL rstmid_ctl got=%b exp=1000", {if3.cmd_ready, if3.in_ready, if3.busy, if3.done});
        else n_pass++;
        step(); step();
        rst = 1'b0;
        for (int n = 0; n < MAXC; n++) begin
            m_acc[n] = 1'b0; m_first[n] = 1'b0; m_done[n] = 1'b0;
            m_busy[n] = 1'b0; m_stream[n] = 1'b0;
        end
        rel = cyc;
        for (int i = 0; i < 6; i++) step();
        for (int n = rel; n < rel + 6; n++) begin
            n_total++;
            if (s_out[n] !== exp_out(n)) $display("FAIL rstmid_tok cyc=%0d got=%h exp=%h", n, s_out[n], exp_out(n));
            else n_pass++;
            n_total++;
            if (s_ctl[n] !== exp_ctl(n)) $display("FAIL rstmid_post cyc=%0d got=%b exp=%b", n, s_ctl[n], exp_ctl(n));
            else n_pass++;
        end
        test_basic();
    endtask

    task automatic test_cmd_held();
        int h1, d1, h2, d2;
        job_gap.delete();
        job_data = '{DW'($urandom), DW'($urandom)};
        drive_job(1'b1, h1, d1);
        job_data = '{DW'($urandom), DW'($urandom)};
        drive_job(1'b0, h2, d2);
        step();
        for (int n = h1; n <= d2 + 1; n++) begin
            n_total++;
            if (s_out[n] !== exp_out(n)) $display("FAIL held_tok cyc=%0d got=%h exp=%h", n, s_out[n], exp_out(n));
            else n_pass++;
            n_total++;
            if (s_ctl[n] !== exp_ctl(n)) $display("FAIL held_ctl cyc=%0d got=%b exp=%b", n, s_ctl[n], exp_ctl(n));
            else n_pass++;
        end
        n_total++;
        if ({s_ctl[d1][3], s_ctl[d1+1][0], s_ctl[d1+2][2:1]} !== 4'b1111)
            $display("FAIL held_b2b got=%b exp=1111", {s_ctl[d1][3], s_ctl[d1+1][0], s_ctl[d1+2][2:1]});
        else n_pass++;
    endtask

    task automatic test_single_col();
        logic [3:0] v;
        v = 4'($urandom);
        if1.cmd_valid = 1'b1; if1.cmd_rows = 8'd1;
        step();
        if1.cmd_valid = 1'b0; if1.cmd_rows = 8'($urandom);
        n_total++;
        if ({if1.busy, if1.in_ready, if1.done} !== 3'b110)
            $display("FAIL col1_stream got=%b exp=110", {if1.busy, if1.in_ready, if1.done});
        else n_pass++;
        if1.in_valid = 1'b1; if1.in_data = v;
        step();
        if1.in_valid = 1'b0;
        n_total++;
        if ({if1.out_start, if1.out_op, if1.out_gauss_op, if1.out_data, if1.done} !== {1'b1, 4'b0001, 2'b11, v, 1'b1})
            $display("FAIL col1_tok got=%b exp=%b", {if1.out_start, if1.out_op, if1.out_gauss_op, if1.out_data, if1.done}, {1'b1, 4'b0001, 2'b11, v, 1'b1});
        else n_pass++;
        step();
        n_total++;
        if ({if1.out_start, if1.out_op, if1.out_gauss_op, if1.out_data, if1.done, if1.busy, if1.cmd_ready} !== 14'b0000000000_0001)
            $display("FAIL col1_after got=%b exp=00000000000001", {if1.out_start, if1.out_op, if1.out_gauss_op, if1.out_data, if1.done, if1.busy, if1.cmd_ready});
        else n_pass++;
    endtask

    task automatic test_random();
        int h, d, first_h, last_d, nrows;
        first_h = 0;
        last_d  = 0;
        for (int j = 0; j < 10; j++) begin
            nrows = (j == 3) ? 255 : (j == 6) ? 0 : int'($urandom_range(1, 6));
            job_data.delete();
            job_gap.delete();
            for (int k = 0; k < nrows; k++) begin
                job_data.push_back(DW'($urandom));
                job_gap.push_back(int'($urandom_range(0, 2)));
            end
            drive_job(1'b0, h, d);
            if (j == 0) first_h = h;
            last_d = d;
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                if3.in_valid = 1'($urandom);
                if3.in_data  = DW'($urandom);
                step();
            end
        end
        if3.in_valid = 1'b0;
        step();
        for (int n = first_h; n <= last_d + 1; n++) begin
            n_total++;
            if (s_out[n] !== exp_out(n)) $display("FAIL rand_tok cyc=%0d got=%h exp=%h", n, s_out[n], exp_out(n));
            else n_pass++;
            n_total++;
            if (s_ctl[n] !== exp_ctl(n)) $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", n, s_ctl[n], exp_ctl(n));
            else n_pass++;
        end
    endtask

    initial begin
        if3.cmd_valid = 1'b0; if3.cmd_rows = '0; if3.in_valid = 1'b0; if3.in_data = '0;
        if1.cmd_valid = 1'b0; if1.cmd_rows = '0; if1.in_valid = 1'b0; if1.in_data = '0;
        test_reset();
        test_basic();
        test_zero_rows();
        test_bubbles();
        test_reset_mid_job();
        test_cmd_held();
        test_single_col();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
